// File: rtl/iiitb_r2_4bit_div_if.sv
// Handshake/data bundle for the radix-2 4-bit divider.
//   load     : start request from the requester
//   N, D     : 8-bit dividend, 4-bit divisor (sampled on the accepting edge)
//   Qo, R    : registered quotient / remainder
//   busy     : divider is stepping
//   done     : one-cycle result-valid pulse
//   err      : divide-by-zero or quotient overflow on the last result
interface iiitb_r2_4bit_div_if;
  logic       load;
  logic [7:0] N;
  logic [3:0] D;
  logic [3:0] Qo;
  logic [3:0] R;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output load, N, D,
    input  Qo, R, busy, done, err
  );

  modport slave (
    input  load, N, D,
    output Qo, R, busy, done, err
  );
endinterface

// File: rtl/iiitb_r2_4bit_div.sv
// Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned
// divisor, one quotient bit per clock, 4-bit quotient and remainder.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of iiitb_r2_4bit_div_if (load/N/D in, Qo/R/busy/done/err out)
// Operands whose quotient cannot fit in 4 bits (N[7:4] >= D, including D == 0)
// are rejected at accept time and complete immediately with err set.
module iiitb_r2_4bit_div (
  input  logic                      clk,
  input  logic                      reset,
  iiitb_r2_4bit_div_if.slave        bus
);

  localparam int unsigned NW = 8;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = DW + 1;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  // Partial remainder. Between steps it is always < D, so its fifth bit is
  // zero and only the low four bits are stored.
  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] qreg_q, qreg_d;
  logic [DW-1:0] dcap_q, dcap_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] qo_q, qo_d;
  logic [DW-1:0] r_q, r_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [AW-1:0] a_sh;
  logic          fits;
  logic          reject;

  // One restoring step: shift {A,Qreg} left and trial-subtract the divisor.
  always_comb begin
    a_sh   = {a_q, qreg_q[DW-1]};
    fits   = (a_sh >= AW'(dcap_q));
    reject = (bus.D == '0) || (bus.N[NW-1:DW] >= bus.D);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qreg_d  = qreg_q;
    dcap_d  = dcap_q;
    cnt_d   = cnt_q;
    qo_d    = qo_q;
    r_d     = r_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          if (reject) begin
            state_d = S_DONE;
            qo_d    = '0;
            r_d     = '0;
            err_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            a_d     = bus.N[NW-1:DW];
            qreg_d  = bus.N[DW-1:0];
            dcap_d  = bus.D;
            cnt_d   = '0;
          end
        end
      end

      S_RUN: begin
        a_d    = fits ? DW'(a_sh - AW'(dcap_q)) : a_sh[DW-1:0];
        qreg_d = {qreg_q[DW-2:0], fits};
        cnt_d  = cnt_q + CW'(1);
        // Fourth step: publish the result and leave RUN.
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_DONE;
          qo_d    = qreg_d;
          r_d     = a_d;
          err_d   = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered copies of the upcoming state decode.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      qreg_q  <= '0;
      dcap_q  <= '0;
      cnt_q   <= '0;
      qo_q    <= '0;
      r_q     <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qreg_q  <= qreg_d;
      dcap_q  <= dcap_d;
      cnt_q   <= cnt_d;
      qo_q    <= qo_d;
      r_q     <= r_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.Qo   = qo_q;
  assign bus.R    = r_q;
  assign bus.err  = err_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_iiitb_r2_4bit_div.sv
// Self-checking bench for iiitb_r2_4bit_div: directed vector table, load
// glitch during RUN, reset abort, reset-with-load, and a full N x D sweep.
// Expected results travel through a scoreboard queue from drive to done.
module tb_iiitb_r2_4bit_div;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  iiitb_r2_4bit_div_if bus ();

  iiitb_r2_4bit_div dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] n;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic exp_t model(input logic [7:0] n, input logic [3:0] d);
    exp_t e;
    if (d == 4'd0 || n[7:4] >= d) begin
      e.q = 4'd0; e.r = 4'd0; e.err = 1'b1; e.lat = 1;
    end else begin
      e.q = 4'(n / 8'(d)); e.r = 4'(n % 8'(d)); e.err = 1'b0; e.lat = 5;
    end
    return e;
  endfunction

  // Called at a negedge with the DUT idle; returns at the first negedge
  // after the accepting edge with operands scrambled.
  task automatic start(input logic [7:0] n, input logic [3:0] d, input exp_t e);
    bus.load = 1'b1;
    bus.N    = n;
    bus.D    = d;
    sb.push_back(e);
    @(negedge clk);
    bus.load = 1'b0;
    bus.N    = 8'($urandom);
    bus.D    = 4'($urandom);
  endtask

  // Waits (bounded) for done, k0 = cycles since accept already reached,
  // busy0 = busy cycles already observed.
  task automatic finish_op(input string tag, input int k0, input int busy0);
    int   k     = k0;
    int   nbusy = busy0;
    exp_t e;
    while (!bus.done && k <= 12) begin
      if (bus.busy) nbusy++;
      @(negedge clk);
      k++;
    end
    check({tag, " done_seen"}, int'(bus.done), 1);
    if (sb.size() == 0) begin
      n_checks++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb.pop_front();
      if (bus.done) begin
        check({tag, " Qo"},      int'(bus.Qo),   int'(e.q));
        check({tag, " R"},       int'(bus.R),    int'(e.r));
        check({tag, " err"},     int'(bus.err),  int'(e.err));
        check({tag, " latency"}, k,              e.lat);
        check({tag, " busy_cycles"}, nbusy,      e.lat - 1);
        check({tag, " busy_with_done"}, int'(bus.busy), 0);
        @(negedge clk);
        check({tag, " done_pulse_width"}, int'(bus.done), 0);
        check({tag, " Qo_hold"}, int'(bus.Qo), int'(e.q));
      end
    end
  endtask

  task automatic expect_quiet(input string tag, input int cycles);
    int spurious = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.done || bus.busy) spurious++;
      @(negedge clk);
    end
    check({tag, " quiet_cycles"}, spurious, 0);
  endtask

  vec_t vecs[10];

  initial begin
    exp_t e;
    int   nb;

    vecs[0] = '{8'd107, 4'd10, 4'd10, 4'd7,  1'b0};
    vecs[1] = '{8'd182, 4'd13, 4'd14, 4'd0,  1'b0};
    vecs[2] = '{8'd0,   4'd1,  4'd0,  4'd0,  1'b0};
    vecs[3] = '{8'd50,  4'd0,  4'd0,  4'd0,  1'b1};
    vecs[4] = '{8'd200, 4'd3,  4'd0,  4'd0,  1'b1};
    vecs[5] = '{8'd27,  4'd5,  4'd5,  4'd2,  1'b0};
    vecs[6] = '{8'd239, 4'd15, 4'd15, 4'd14, 1'b0};
    vecs[7] = '{8'd255, 4'd15, 4'd0,  4'd0,  1'b1};
    vecs[8] = '{8'd16,  4'd1,  4'd0,  4'd0,  1'b1};
    vecs[9] = '{8'd15,  4'd1,  4'd15, 4'd0,  1'b0};

    // Reset with load held high: load must be ignored.
    reset    = 1'b1;
    bus.load = 1'b1;
    bus.N    = 8'd107;
    bus.D    = 4'd10;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    bus.load = 1'b0;
    check("reset Qo",   int'(bus.Qo),   0);
    check("reset R",    int'(bus.R),    0);
    check("reset err",  int'(bus.err),  0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    expect_quiet("reset_with_load", 4);

    // Directed table.
    foreach (vecs[i]) begin
      e.q   = vecs[i].q;
      e.r   = vecs[i].r;
      e.err = vecs[i].err;
      e.lat = vecs[i].err ? 1 : 5;
      start(vecs[i].n, vecs[i].d, e);
      finish_op($sformatf("vec%0d", i), 1, 0);
    end

    // Load pulse on the 2nd RUN cycle must be ignored.
    start(8'd107, 4'd10, model(8'd107, 4'd10));
    nb = int'(bus.busy);
    @(negedge clk);
    nb += int'(bus.busy);
    bus.load = 1'b1;
    bus.N    = 8'd15;
    bus.D    = 4'd1;
    @(negedge clk);
    bus.load = 1'b0;
    finish_op("glitch", 3, nb);
    expect_quiet("glitch_after", 6);

    // Reset on the 3rd RUN cycle aborts the operation.
    start(8'd182, 4'd13, model(8'd182, 4'd13));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_back());
    check("abort Qo",   int'(bus.Qo),   0);
    check("abort R",    int'(bus.R),    0);
    check("abort err",  int'(bus.err),  0);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    expect_quiet("abort_after", 6);
    start(8'd107, 4'd10, model(8'd107, 4'd10));
    finish_op("after_abort", 1, 0);

    // Exhaustive sweep.
    for (int n = 0; n < 256; n++) begin
      for (int d = 0; d < 16; d++) begin
        e = model(8'(n), 4'(d));
        start(8'(n), 4'(d), e);
        finish_op($sformatf("sweep n=%0d d=%0d", n, d), 1, 0);
        if (!e.err) begin
          check($sformatf("sweep identity n=%0d d=%0d", n, d),
                int'(bus.Qo) * d + int'(bus.R), n);
          check($sformatf("sweep r_lt_d n=%0d d=%0d", n, d),
                int'(int'(bus.R) < d), 1);
        end
      end
    end

    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
